// File: rtl/frame_buffer_pkg.sv
// Shared types and defaults for the frame output buffer: storage word layout,
// frame checker states and the upstream-ready slack rule.
package frame_buffer_pkg;

    localparam int unsigned FrameDataW   = 16;
    localparam int unsigned DefaultSlack = 18;

    typedef struct packed {
        logic                  start;
        logic                  last;
        logic [FrameDataW-1:0] data;
    } frame_word_t;

    typedef enum logic [0:0] {StIdle, StInFrame} frame_state_t;

    // Upstream may keep streaming only while more than `slack` entries stay free.
    function automatic logic ready_from_level(input int unsigned depth,
                                              input int unsigned slack,
                                              input int unsigned lvl);
        return (depth - lvl) > slack;
    endfunction

endpackage

// File: rtl/frame_output_buffer_if.sv
// Framed valid/ready stream with start/last markers; master drives the word.
interface frame_output_buffer_if
    import frame_buffer_pkg::*;
#(
    parameter int unsigned DATA_W = FrameDataW
) ();

    logic [DATA_W-1:0] data;
    logic              valid;
    logic              start;
    logic              last;
    logic              ready;

    modport master (output data, valid, start, last, input ready);
    modport slave  (input data, valid, start, last, output ready);

endinterface

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO with separate occupancy counter; a write while
// full is accepted only if a pop happens in the same cycle, otherwise dropped.
module sync_fifo_fwft #(
    parameter int unsigned WIDTH = 18,
    parameter int unsigned DEPTH = 32
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     wr_valid,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_ready,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_valid,
    output logic                     dropped,
    output logic [$clog2(DEPTH):0]   level,
    output logic [$clog2(DEPTH):0]   level_next
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]    level_q, level_d;
    logic             full, push, pop;

    assign rd_valid = (level_q != '0);
    assign full     = (level_q == LW'(DEPTH));
    assign pop      = rd_valid && rd_ready;
    assign push     = wr_valid && (!full || pop);
    assign dropped  = wr_valid && !push;

    always_comb begin
        level_d = level_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q <= level_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge aclk) begin
        if (push) mem[wr_ptr_q] <= wr_data;
    end

    assign rd_data    = mem[rd_ptr_q];
    assign level      = level_q;
    assign level_next = level_d;

endmodule

// File: rtl/frame_output_buffer.sv
// Buffers the divider's unthrottled framed stream, drives a backpressured output,
// flags overflow and counts delivered frames. Framing checker: FRAME_OUTPUT_BUFFER_CHECK_EN.
module frame_output_buffer
    import frame_buffer_pkg::*;
#(
    parameter int unsigned DATA_W = FrameDataW,
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned SLACK  = DefaultSlack
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    frame_output_buffer_if.slave   s,
    frame_output_buffer_if.master  m,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic                   frame_err,
    output logic [15:0]            frame_count
);

    localparam int unsigned WordW = DATA_W + 2;

    logic [WordW-1:0]        rd_word;
    logic [$clog2(DEPTH):0]  level_next;
    logic                    dropped, pop;
    logic                    s_ready_q, overflow_q;
    logic [15:0]             frame_count_q;

    sync_fifo_fwft #(
        .WIDTH (WordW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .wr_valid   (s.valid),
        .wr_data    ({s.start, s.last, s.data}),
        .rd_ready   (m.ready),
        .rd_data    (rd_word),
        .rd_valid   (m.valid),
        .dropped    (dropped),
        .level      (level),
        .level_next (level_next)
    );

    assign m.start = rd_word[WordW-1];
    assign m.last  = rd_word[WordW-2];
    assign m.data  = rd_word[DATA_W-1:0];
    assign pop     = m.valid && m.ready;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            s_ready_q     <= 1'b0;
            overflow_q    <= 1'b0;
            frame_count_q <= '0;
        end else begin
            s_ready_q <= ready_from_level(DEPTH, SLACK, 32'(level_next));
            if (dropped)          overflow_q    <= 1'b1;
            if (pop && m.last)    frame_count_q <= frame_count_q + 16'd1;
        end
    end

    assign s.ready     = s_ready_q;
    assign overflow    = overflow_q;
    assign frame_count = frame_count_q;

`ifdef FRAME_OUTPUT_BUFFER_CHECK_EN
    frame_state_t state_q, state_d;
    logic         err_set, frame_err_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state_q <= StIdle;
        else          state_q <= state_d;
    end

    // Dropped words are still checked: framing is a property of the input stream.
    always_comb begin
        state_d = state_q;
        if (s.valid) begin
            unique case (state_q)
                StIdle:    if (s.start && !s.last) state_d = StInFrame;
                StInFrame: if (s.last && !s.start) state_d = StIdle;
                default:   state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        err_set = 1'b0;
        if (s.valid) begin
            unique case (state_q)
                StIdle:    err_set = !s.start;
                StInFrame: err_set = s.start;
                default:   err_set = 1'b0;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)     frame_err_q <= 1'b0;
        else if (err_set) frame_err_q <= 1'b1;
    end

    assign frame_err = frame_err_q;
`else
    assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_frame_output_buffer.sv
// Randomized and directed bench for frame_output_buffer against a queue-based model.
module tb_frame_output_buffer;
    import frame_buffer_pkg::*;

    localparam int DW    = 16;
    localparam int DEPTH = 32;
    localparam int SLACK = 18;

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    frame_output_buffer_if #(.DATA_W(DW)) s_if ();
    frame_output_buffer_if #(.DATA_W(DW)) m_if ();

    logic [5:0]  level;
    logic        overflow, frame_err;
    logic [15:0] frame_count;

    frame_output_buffer #(
        .DATA_W (DW),
        .DEPTH  (DEPTH),
        .SLACK  (SLACK)
    ) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .s           (s_if.slave),
        .m           (m_if.master),
        .level       (level),
        .overflow    (overflow),
        .frame_err   (frame_err),
        .frame_count (frame_count)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    frame_word_t q[$];
    frame_word_t exp_pop[$];
    frame_word_t got_pop[$];
    bit          m_ovf, m_err, m_in_frame, m_rdy;
    logic [15:0] m_cnt;

    `ifdef FRAME_OUTPUT_BUFFER_CHECK_EN
    localparam bit CheckEn = 1'b1;
    `else
    localparam bit CheckEn = 1'b0;
    `endif

    task automatic model_reset();
        q.delete();
        m_ovf = 0; m_err = 0; m_in_frame = 0; m_rdy = 0; m_cnt = '0;
    endtask

    task automatic model_edge(input bit v, input bit st, input bit la,
                              input logic [15:0] d, input bit mr);
        bit pop, push;
        frame_word_t w;
        if (!aresetn) begin
            model_reset();
            return;
        end
        pop  = (q.size() != 0) && mr;
        push = v && (q.size() < DEPTH || pop);
        if (pop) begin
            w = q.pop_front();
            exp_pop.push_back(w);
            if (w.last) m_cnt = m_cnt + 16'd1;
        end
        if (push) q.push_back('{start: st, last: la, data: d});
        if (v && !push) m_ovf = 1;
        if (v && CheckEn) begin
            if (!m_in_frame) begin
                if (!st) m_err = 1;
                else if (!la) m_in_frame = 1;
            end else begin
                if (st) m_err = 1;
                else if (la) m_in_frame = 0;
            end
        end
        m_rdy = (DEPTH - q.size()) > SLACK;
    endtask

    task automatic cycle(input bit v, input bit st, input bit la,
                         input logic [15:0] d, input bit mr);
        s_if.valid = v; s_if.start = st; s_if.last = la; s_if.data = d;
        m_if.ready = mr;
        @(negedge aclk);
        if (m_if.valid && m_if.ready)
            got_pop.push_back('{start: m_if.start, last: m_if.last, data: m_if.data});
        @(posedge aclk);
        model_edge(v, st, la, d, mr);
        #1;
    endtask

    function automatic logic [25:0] dut_status();
        return {level, m_if.valid, s_if.ready, overflow, frame_err, frame_count};
    endfunction

    function automatic logic [25:0] model_status();
        return {6'(q.size()), q.size() != 0, m_rdy, m_ovf, m_err, m_cnt};
    endfunction

    task automatic test_reset();
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, '0, 0);
        n_cmp++;
        if (dut_status() !== 26'd0) begin
            n_bad++; $display("FAIL reset_hold got=%h exp=%h", dut_status(), 26'd0);
        end
        aresetn = 1'b1;
        cycle(0, 0, 0, '0, 0);
        n_cmp++;
        if (s_if.ready !== 1'b1 || m_if.valid !== 1'b0 || level !== 6'd0) begin
            n_bad++;
            $display("FAIL reset_release got rdy=%b mv=%b lvl=%0d exp rdy=1 mv=0 lvl=0",
                     s_if.ready, m_if.valid, level);
        end
    endtask

    task automatic test_frame();
        logic [15:0] words [4] = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400};
        exp_pop.delete(); got_pop.delete();
        for (int i = 0; i < 4; i++) cycle(1, i == 0, i == 3, words[i], 1);
        cycle(0, 0, 0, '0, 1);
        n_cmp++;
        if (got_pop.size() != 4) begin
            n_bad++; $display("FAIL frame_pops got=%0d exp=4", got_pop.size());
        end
        for (int i = 0; i < got_pop.size() && i < 4; i++) begin
            n_cmp++;
            if (got_pop[i] !== exp_pop[i] || got_pop[i].data !== words[i]) begin
                n_bad++;
                $display("FAIL frame_word%0d got=%h exp=%h", i, got_pop[i], exp_pop[i]);
            end
        end
        n_cmp++;
        if (frame_count !== 16'd1 || frame_err !== 1'b0 || dut_status() !== model_status()) begin
            n_bad++;
            $display("FAIL frame_status got cnt=%0d err=%b exp cnt=1 err=0", frame_count,
                     frame_err);
        end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 33; i++) begin
            cycle(1, i == 1, 0, 16'($urandom), 0);
            n_cmp++;
            if (dut_status() !== model_status()) begin
                n_bad++;
                $display("FAIL fill_status%0d got=%h exp=%h", i, dut_status(), model_status());
            end
            if (i == 13 || i == 14) begin
                n_cmp++;
                if (s_if.ready !== (i == 13) || level !== 6'(i)) begin
                    n_bad++;
                    $display("FAIL fill_ready%0d got rdy=%b lvl=%0d exp rdy=%b lvl=%0d", i,
                             s_if.ready, level, i == 13, i);
                end
            end
            if (i == 32 || i == 33) begin
                n_cmp++;
                if (level !== 6'd32 || overflow !== (i == 33)) begin
                    n_bad++;
                    $display("FAIL fill_full%0d got lvl=%0d ovf=%b exp lvl=32 ovf=%b", i,
                             level, overflow, i == 33);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_pop.delete(); got_pop.delete();
        for (int i = 0; i < 5; i++) begin
            cycle(1, 0, i == 4, 16'($urandom), 1);
            n_cmp++;
            if (level !== 6'd32 || dut_status() !== model_status()) begin
                n_bad++;
                $display("FAIL b2b_level%0d got=%h exp=%h", i, dut_status(), model_status());
            end
        end
        for (int i = 0; i < 34; i++) cycle(0, 0, 0, '0, 1);
        n_cmp++;
        if (got_pop.size() != exp_pop.size() || got_pop.size() != 37) begin
            n_bad++;
            $display("FAIL b2b_pops got=%0d exp=%0d", got_pop.size(), exp_pop.size());
        end
        for (int i = 0; i < got_pop.size() && i < exp_pop.size(); i++) begin
            n_cmp++;
            if (got_pop[i] !== exp_pop[i]) begin
                n_bad++; $display("FAIL b2b_order%0d got=%h exp=%h", i, got_pop[i], exp_pop[i]);
            end
        end
        n_cmp++;
        if (level !== 6'd0 || frame_count !== 16'd2 || dut_status() !== model_status()) begin
            n_bad++;
            $display("FAIL b2b_drain got=%h exp=%h", dut_status(), model_status());
        end
    endtask

    task automatic test_frame_err();
        cycle(1, 0, 0, 16'h1234, 1);
        cycle(0, 0, 0, '0, 1);
        n_cmp++;
        if (frame_err !== CheckEn || dut_status() !== model_status()) begin
            n_bad++;
            $display("FAIL frame_err got err=%b exp err=%b", frame_err, CheckEn);
        end
    endtask

    task automatic test_random();
        exp_pop.delete(); got_pop.delete();
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) == 0, 16'($urandom), $urandom_range(0, 1) == 1);
            n_cmp++;
            if (dut_status() !== model_status()) begin
                n_bad++;
                $display("FAIL rand_status%0d got=%h exp=%h", i, dut_status(), model_status());
            end
        end
        n_cmp++;
        if (got_pop.size() != exp_pop.size()) begin
            n_bad++;
            $display("FAIL rand_pops got=%0d exp=%0d", got_pop.size(), exp_pop.size());
        end
        for (int i = 0; i < got_pop.size() && i < exp_pop.size(); i++) begin
            if (got_pop[i] !== exp_pop[i]) begin
                n_cmp++; n_bad++;
                $display("FAIL rand_order%0d got=%h exp=%h", i, got_pop[i], exp_pop[i]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        for (int i = 0; i < 40; i++) cycle(0, 0, 0, '0, 1);
        for (int i = 0; i < 7; i++) cycle(1, i == 0, 0, 16'($urandom), 0);
        n_cmp++;
        if (level !== 6'd7) begin
            n_bad++; $display("FAIL midrst_level got=%0d exp=7", level);
        end
        aresetn = 1'b0;
        #1;
        n_cmp++;
        if (dut_status() !== 26'd0) begin
            n_bad++; $display("FAIL midrst_async got=%h exp=%h", dut_status(), 26'd0);
        end
        model_reset();
        cycle(0, 0, 0, '0, 0);
        aresetn = 1'b1;
        cycle(0, 0, 0, '0, 0);
        for (int i = 0; i < 3; i++) cycle(1, i == 0, i == 2, 16'($urandom), 1);
        cycle(0, 0, 0, '0, 1);
        n_cmp++;
        if (frame_count !== 16'd1 || frame_err !== 1'b0 || level !== 6'd0 ||
            dut_status() !== model_status()) begin
            n_bad++;
            $display("FAIL midrst_frame got cnt=%0d err=%b lvl=%0d exp cnt=1 err=0 lvl=0",
                     frame_count, frame_err, level);
        end
    endtask

    initial begin
        s_if.valid = 0; s_if.start = 0; s_if.last = 0; s_if.data = '0;
        m_if.ready = 0;
        model_reset();
        test_reset();
        test_frame();
        test_fill();
        test_back_to_back();
        test_frame_err();
        test_random();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
